apb_initiator: RTL and testbench

- Converts a simple request/grant/response bus (core or debug side) into APB transfers.
- Drives the slave port of the APB interconnect node, which decodes the address and forwards the transfer to the selected peripheral.
- Runs the APB SETUP/ACCESS sequence, honours pready wait states, and returns read data and errors to the requester.

---
 rtl/apb_initiator.sv | 109 ++++++++++
 tb/tb_apb_initiator.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_initiator.sv
// Request/grant/response to APB bridge: runs SETUP/ACCESS, honours pready wait states,
// returns read data and slave errors. Optional ACCESS timeout: APB_INITIATOR_TIMEOUT_EN.
module apb_initiator #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  // Requester side: gnt_o is the ready for req_i (a transfer is taken when req_i && gnt_o);
  // rvalid_o is an unconditional one-cycle response with no back-pressure.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state_q, state_d;
  logic   complete;
  logic   abort;

  assign complete = (state_q == ACCESS) && pready_i;

`ifdef APB_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // Held at zero outside ACCESS, so every ACCESS phase starts from a cleared count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q != ACCESS) begin
      cnt_q <= '0;
    end else if (!pready_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign abort = (state_q == ACCESS) && !pready_i &&
                 (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No timeout compiled in: the limit can never be reached.
  assign abort = (TIMEOUT_CYCLES < 0);
`endif

  assign gnt_o     = !rst_i && req_i && ((state_q == IDLE) || complete);
  assign psel_o    = (state_q != IDLE);
  assign penable_o = (state_q == ACCESS);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_o) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (complete) begin
          state_d = gnt_o ? SETUP : IDLE;
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwrite_o <= 1'b0;
      paddr_o  <= '0;
      pwdata_o <= '0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      if (gnt_o) begin
        pwrite_o <= we_i;
        paddr_o  <= addr_i;
        pwdata_o <= wdata_i;
      end
      // Response fields are zero except during the single rvalid_o cycle.
      rvalid_o <= complete || abort;
      err_o    <= complete ? pslverr_i : abort;
      rdata_o  <= (complete && !pwrite_o) ? prdata_i : '0;
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: directed protocol steps, then randomized transfers against
// a transaction-level model (scripted slave plus expected-response queue).
module tb_apb_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  apb_initiator #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Transaction script shared by driver, slave model and scoreboard.
  logic          t_we[N];
  logic [AW-1:0] t_addr[N];
  logic [DW-1:0] t_wdata[N];
  int            t_waits[N];
  logic [DW-1:0] t_rdata[N];
  logic          t_err[N];
  logic [DW:0]   exp_q[$];

  logic rand_on = 1'b0;
  int   s_idx = 0;
  int   w_cnt = 0;
  int   n_resp = 0;
  logic comp_prev = 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          g;
    int            bound;
    logic [DW:0]   e;

    // Slave model: follows the script, randomizes everything outside ACCESS.
    fork
      forever begin
        @(posedge clk);
        #1;
        if (rand_on) begin
          if (psel && s_idx < N) begin
            chk("slv_paddr", paddr, t_addr[s_idx]);
            chk("slv_pwrite", pwrite, t_we[s_idx]);
            if (t_we[s_idx]) chk("slv_pwdata", pwdata, t_wdata[s_idx]);
          end
          if (psel && penable && s_idx < N) begin
            if (w_cnt < t_waits[s_idx]) begin
              pready = 1'b0;
              prdata = $urandom;
              pslverr = 1'($urandom);
              w_cnt++;
            end else begin
              pready = 1'b1;
              prdata = t_rdata[s_idx];
              pslverr = t_err[s_idx];
              w_cnt = 0;
              s_idx++;
            end
          end else begin
            pready = 1'($urandom);
            prdata = $urandom;
            pslverr = 1'($urandom);
          end
        end
      end
      forever begin
        @(negedge clk);
        if (rand_on) begin
          chk("rv_timing", rvalid, comp_prev);
          if (rvalid) begin
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              n_resp++;
              chk("rnd_rdata", rdata, e[DW-1:0]);
              chk("rnd_err", err, e[DW]);
            end else begin
              chk("rnd_unexpected_rvalid", rvalid, 1'b0);
            end
          end else begin
            chk("rnd_rdata_idle", rdata, 0);
            chk("rnd_err_idle", err, 0);
          end
          comp_prev = psel && penable && pready;
        end
      end
    join_none

    // Reset: all outputs zero, no grant even with a request pending.
    req = 1'b1;
    nxt(); nxt();
    neg();
    chk("rst_gnt", gnt, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    nxt();
    rst = 1'b0; req = 1'b0;
    nxt();

    // Write, zero wait states.
    req = 1'b1; we = 1'b1; addr = 32'h1A10_0004; wdata = 32'hDEAD_BEEF; pready = 1'b1;
    prdata = $urandom;
    neg();
    chk("w0_gnt", gnt, 1); chk("w0_psel_c0", psel, 0);
    nxt(); req = 1'b0; addr = $urandom; wdata = $urandom;
    neg();
    chk("w0_psel_c1", psel, 1); chk("w0_pen_c1", penable, 0); chk("w0_gnt_setup", gnt, 0);
    chk("w0_paddr", paddr, 32'h1A10_0004); chk("w0_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("w0_pwrite", pwrite, 1);
    nxt();
    neg();
    chk("w0_pen_c2", penable, 1); chk("w0_psel_c2", psel, 1); chk("w0_rvalid_c2", rvalid, 0);
    nxt();
    neg();
    chk("w0_rvalid_c3", rvalid, 1); chk("w0_err_c3", err, 0); chk("w0_rdata_c3", rdata, 0);
    chk("w0_psel_c3", psel, 0);
    nxt();
    neg();
    chk("w0_rvalid_c4", rvalid, 0);

    // Read with three wait states; pslverr/prdata junk while not ready.
    nxt();
    a = $urandom;
    req = 1'b1; we = 1'b0; addr = a; pready = 1'b0;
    neg();
    chk("r3_gnt", gnt, 1);
    nxt(); req = 1'b0; addr = ~a;
    neg();
    chk("r3_setup_pen", penable, 0); chk("r3_setup_paddr", paddr, a);
    for (int i = 0; i < 3; i++) begin
      nxt(); pslverr = 1'b1; prdata = $urandom; req = 1'b1;
      neg();
      chk("r3_wait_pen", penable, 1); chk("r3_wait_paddr", paddr, a);
      chk("r3_wait_gnt", gnt, 0); chk("r3_wait_rvalid", rvalid, 0);
    end
    nxt(); req = 1'b0; pready = 1'b1; pslverr = 1'b0; prdata = 32'h1234_5678;
    neg();
    chk("r3_last_paddr", paddr, a); chk("r3_last_pwrite", pwrite, 0);
    nxt(); pready = 1'b0; prdata = $urandom;
    neg();
    chk("r3_rvalid", rvalid, 1); chk("r3_rdata", rdata, 32'h1234_5678); chk("r3_err", err, 0);
    chk("r3_psel_after", psel, 0);
    nxt();
    neg();
    chk("r3_rvalid_clr", rvalid, 0); chk("r3_rdata_clr", rdata, 0);

    // Back-to-back writes to 0x0, 0x4, 0x8 with request held.
    nxt();
    req = 1'b1; we = 1'b1; addr = 32'h0; wdata = $urandom; pready = 1'b1;
    neg();
    chk("b2b_gnt0", gnt, 1);
    for (int i = 0; i < 3; i++) begin
      nxt(); addr = 32'((i + 1) * 4); req = (i < 2); wdata = $urandom;
      neg();
      chk("b2b_setup_psel", psel, 1); chk("b2b_setup_pen", penable, 0);
      chk("b2b_setup_paddr", paddr, 32'(i * 4)); chk("b2b_setup_rvalid", rvalid, (i > 0));
      nxt();
      neg();
      chk("b2b_acc_psel", psel, 1); chk("b2b_acc_pen", penable, 1);
      chk("b2b_acc_gnt", gnt, (i < 2));
    end
    nxt(); req = 1'b0;
    neg();
    chk("b2b_last_rvalid", rvalid, 1); chk("b2b_last_psel", psel, 0);

    // Slave error on a read.
    nxt();
    req = 1'b1; we = 1'b0; addr = $urandom; pready = 1'b1; pslverr = 1'b1;
    prdata = 32'hFFFF_FFFF;
    nxt(); req = 1'b0;
    nxt();
    nxt(); pslverr = 1'b0; prdata = '0;
    neg();
    chk("serr_rvalid", rvalid, 1); chk("serr_err", err, 1); chk("serr_rdata", rdata, 32'hFFFF_FFFF);
    nxt();
    neg();
    chk("serr_err_clr", err, 0); chk("serr_rdata_clr", rdata, 0);

    // Reset during ACCESS, then a normal read.
    nxt();
    req = 1'b1; we = 1'b1; addr = $urandom; pready = 1'b0;
    nxt(); req = 1'b0;
    nxt();
    nxt(); rst = 1'b1; req = 1'b1;
    neg();
    chk("mrst_gnt", gnt, 0);
    nxt(); rst = 1'b0; req = 1'b0;
    neg();
    chk("mrst_psel", psel, 0); chk("mrst_pen", penable, 0); chk("mrst_rvalid", rvalid, 0);
    nxt();
    neg();
    chk("mrst_no_resp", rvalid, 0);
    nxt();
    d = $urandom;
    req = 1'b1; we = 1'b0; addr = $urandom; pready = 1'b1; prdata = d;
    neg();
    chk("mrst_new_gnt", gnt, 1);
    nxt(); req = 1'b0;
    nxt();
    nxt();
    neg();
    chk("mrst_new_rvalid", rvalid, 1); chk("mrst_new_rdata", rdata, d);

    // Randomized transfers against the script.
    for (int i = 0; i < N; i++) begin
      t_we[i]    = 1'($urandom);
      t_addr[i]  = $urandom;
      t_wdata[i] = $urandom;
      t_waits[i] = $urandom_range(0, 3);
      t_rdata[i] = $urandom;
      t_err[i]   = ($urandom_range(0, 4) == 0);
      exp_q.push_back({t_err[i], t_we[i] ? {DW{1'b0}} : t_rdata[i]});
    end
    nxt();
    req = 1'b0;
    rand_on = 1'b1;
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 2)) begin
        req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
        nxt();
      end
      req = 1'b1; we = t_we[i]; addr = t_addr[i]; wdata = t_wdata[i];
      bound = 0;
      do begin
        neg();
        g = gnt;
        nxt();
        bound++;
      end while (!g && bound < 40);
      if (!g) chk("rnd_gnt_timeout", g, 1);
    end
    req = 1'b0;
    bound = 0;
    while ((exp_q.size() > 0) && bound < 200) begin
      nxt();
      bound++;
    end
    nxt(); nxt();
    rand_on = 1'b0;
    chk("rnd_resp_count", n_resp, N);
    chk("rnd_slave_count", s_idx, N);

`ifdef APB_INITIATOR_TIMEOUT_EN
    // Timeout with pready held low for 4 ACCESS cycles.
    nxt();
    req = 1'b1; we = 1'b0; addr = $urandom; pready = 1'b0; prdata = $urandom; pslverr = 1'b0;
    nxt(); req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      neg();
      chk("to_acc_pen", penable, 1); chk("to_acc_rvalid", rvalid, 0);
    end
    nxt();
    neg();
    chk("to_psel", psel, 0); chk("to_pen", penable, 0);
    chk("to_rvalid", rvalid, 1); chk("to_err", err, 1); chk("to_rdata", rdata, 0);
`endif

    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
